// File: rtl/data_mem_pkg.sv
// Shared types and constants for the wait-state data memory.
// The response data constants make idle and error cycles easy to spot on a waveform.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  localparam logic [31:0] MEM_IDLE_DATA = 32'hfa11_1eaf;
  localparam logic [31:0] MEM_ERR_DATA  = 32'hdead_beef;

endpackage

// File: rtl/data_mem_bus_if.sv
// LSU-to-data-memory request/response bus.
// Signal names carry the memory's point of view (_i into the memory, _o out of it).
interface data_mem_bus_if;

  logic        mem_req_i;
  logic        write_enable_i;
  logic [3:0]  byte_enable_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        ready_o;
  logic        error_o;

  modport master (
    output mem_req_i, write_enable_i, byte_enable_i, addr_i, write_data_i,
    input  read_data_o, ready_o, error_o
  );

  modport slave (
    input  mem_req_i, write_enable_i, byte_enable_i, addr_i, write_data_i,
    output read_data_o, ready_o, error_o
  );

endinterface

// File: rtl/mem_ram_be.sv
// Single-port word RAM with synchronous read and per-byte write enables.
// A write cycle leaves the read register untouched.
module mem_ram_be #(
  parameter  int unsigned DEPTH_WORDS = 4096,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: the storage array and its read register have no reset; a reset
  // branch would stop the array mapping onto a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_bus.sv
// Data memory with configurable wait states, byte-lane writes and a ready/error response.
// Requests are captured in IDLE, held through WAIT, and answered in a single RESP cycle.
module data_mem_bus
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  data_mem_bus_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic        rd_ok_q, rd_ok_d;

  logic [31:0] offset;
  logic        bad_addr;
  logic        resp_next;
  logic        ram_en;
  logic [31:0] ram_rdata;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_req_i) begin
          we_d    = bus.write_enable_i;
          be_d    = bus.byte_enable_i;
          addr_d  = bus.addr_i;
          wdata_d = bus.write_data_i;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode runs on addr_d so that with LATENCY=1 the RAM access can happen on
  // the acceptance edge itself. The base is aligned, so offset[1:0] == addr[1:0].
  always_comb begin
    offset    = addr_d - BASE_ADDR;
    bad_addr  = (offset[31:IDX_W+2] != '0) || (offset[1:0] != 2'b00);
    resp_next = (state_d == RESP);
    ram_en    = rst_ni && resp_next && !bad_addr;
    ready_d   = resp_next;
    error_d   = resp_next && bad_addr;
    rd_ok_d   = resp_next && !bad_addr && !we_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  mem_ram_be #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk_i  (clk_i),
    .en_i   (ram_en),
    .we_i   (we_d),
    .be_i   (be_d),
    .idx_i  (offset[IDX_W+1:2]),
    .wdata_i(wdata_d),
    .rdata_o(ram_rdata)
  );

  assign bus.ready_o     = ready_q;
  assign bus.error_o     = error_q;
  assign bus.read_data_o = rd_ok_q ? ram_rdata : (error_q ? MEM_ERR_DATA : MEM_IDLE_DATA);

endmodule

// File: tb/tb_data_mem_bus.sv
// Bench for data_mem_bus: two instances (LATENCY=3 at base 0, LATENCY=1 at base 0x1000)
// share one stimulus stream and are compared every cycle against a transaction-level model.
module tb_data_mem_bus;
  import data_mem_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req  = 1'b0;
  logic        we   = 1'b0;
  logic [3:0]  be   = '0;
  logic [31:0] addr = '0;
  logic [31:0] wd   = '0;

  data_mem_bus_if bus0 ();
  data_mem_bus_if bus1 ();

  assign bus0.mem_req_i      = req;
  assign bus0.write_enable_i = we;
  assign bus0.byte_enable_i  = be;
  assign bus0.addr_i         = addr;
  assign bus0.write_data_i   = wd;
  assign bus1.mem_req_i      = req;
  assign bus1.write_enable_i = we;
  assign bus1.byte_enable_i  = be;
  assign bus1.addr_i         = addr;
  assign bus1.write_data_i   = wd;

  data_mem_bus #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0000_0000), .LATENCY(3)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0)
  );
  data_mem_bus #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int          lat_p   [2] = '{3, 1};
  int          depth_p [2] = '{4096, 16};
  logic [31:0] base_p  [2] = '{32'h0000_0000, 32'h0000_1000};

  int          edge_cnt = 0;
  bit          pend    [2] = '{0, 0};
  int          acc_at  [2] = '{0, 0};
  int          busy_to [2] = '{0, 0};
  logic        p_we    [2];
  logic [3:0]  p_be    [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wd    [2];
  logic [31:0] mem     [int];

  bit          exp_rdy   [2] = '{0, 0};
  bit          exp_err   [2] = '{0, 0};
  logic [31:0] exp_dat   [2] = '{MEM_IDLE_DATA, MEM_IDLE_DATA};
  bit          exp_known [2] = '{1, 1};

  task automatic model_step(input int k);
    logic [31:0] off;
    logic [31:0] w;
    int          key;
    exp_rdy[k]   = 1'b0;
    exp_err[k]   = 1'b0;
    exp_dat[k]   = MEM_IDLE_DATA;
    exp_known[k] = 1'b1;
    if (!pend[k] && edge_cnt > busy_to[k] && req) begin
      pend[k]    = 1'b1;
      acc_at[k]  = edge_cnt;
      busy_to[k] = edge_cnt + lat_p[k];
      p_we[k]    = we;
      p_be[k]    = be;
      p_addr[k]  = addr;
      p_wd[k]    = wd;
    end
    if (pend[k] && edge_cnt == acc_at[k] + lat_p[k] - 1) begin
      pend[k]    = 1'b0;
      exp_rdy[k] = 1'b1;
      off = p_addr[k] - base_p[k];
      if (longint'(off) >= 4 * longint'(depth_p[k]) || p_addr[k][1:0] != 2'b00) begin
        exp_err[k] = 1'b1;
        exp_dat[k] = MEM_ERR_DATA;
      end else begin
        key = k * 65536 + int'(off / 4);
        if (p_we[k]) begin
          if (p_be[k] == 4'hF) begin
            mem[key] = p_wd[k];
          end else if (mem.exists(key)) begin
            w = mem[key];
            for (int b = 0; b < 4; b++) if (p_be[k][b]) w[8*b +: 8] = p_wd[k][8*b +: 8];
            mem[key] = w;
          end
        end else if (mem.exists(key)) begin
          exp_dat[k] = mem[key];
        end else begin
          exp_known[k] = 1'b0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      edge_cnt++;
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  always @(negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      pend[k]      = 1'b0;
      busy_to[k]   = edge_cnt;
      exp_rdy[k]   = 1'b0;
      exp_err[k]   = 1'b0;
      exp_dat[k]   = MEM_IDLE_DATA;
      exp_known[k] = 1'b1;
    end
  end

  task automatic cmp_inst(input int k, input logic r, input logic e, input logic [31:0] d);
    check($sformatf("i%0d_ready@%0d", k, edge_cnt), 32'(r), 32'(exp_rdy[k]));
    check($sformatf("i%0d_error@%0d", k, edge_cnt), 32'(e), 32'(exp_err[k]));
    if (exp_known[k]) check($sformatf("i%0d_rdata@%0d", k, edge_cnt), d, exp_dat[k]);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp_inst(0, bus0.ready_o, bus0.error_o, bus0.read_data_o);
      cmp_inst(1, bus1.ready_o, bus1.error_o, bus1.read_data_o);
    end
  end

  // ---------------- directed transaction driver ----------------
  task automatic txn(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd0, output logic e0, output int l0,
                     output logic [31:0] rd1, output logic e1, output int l1);
    rd0 = '0; e0 = 1'b0; l0 = -1;
    rd1 = '0; e1 = 1'b0; l1 = -1;
    @(negedge clk);
    req = 1'b1; we = w; be = b; addr = a; wd = d;
    @(posedge clk);
    @(negedge clk);
    // Scramble the bus after acceptance; the captured request must not change.
    req = 1'b0; we = 1'($urandom); be = 4'($urandom); addr = $urandom; wd = $urandom;
    for (int i = 1; i <= 20 && (l0 < 0 || l1 < 0); i++) begin
      if (l0 < 0 && bus0.ready_o) begin l0 = i; rd0 = bus0.read_data_o; e0 = bus0.error_o; end
      if (l1 < 0 && bus1.ready_o) begin l1 = i; rd1 = bus1.read_data_o; e1 = bus1.error_o; end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rd0, rd1;
    logic        e0, e1;
    int          l0, l1;
    logic        r0 [12];
    logic        r1 [12];
    int          pulses;

    #1;
    check("rst_ready", 32'(bus0.ready_o), 32'h0);
    check("rst_error", 32'(bus0.error_o), 32'h0);
    check("rst_rdata", bus0.read_data_o, 32'hfa11_1eaf);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Preload every word the random phase touches so reads have known contents.
    for (int i = 0; i < 32; i++) begin
      txn(1'b1, 4'hF, 32'(i * 4), 32'h5000_0000 + 32'(i), rd0, e0, l0, rd1, e1, l1);
      txn(1'b1, 4'hF, 32'h1000 + 32'(i * 4), 32'h6000_0000 + 32'(i), rd0, e0, l0, rd1, e1, l1);
    end

    // Full-word write then read, LATENCY=3 timing.
    txn(1'b1, 4'hF, 32'h10, 32'h1234_5678, rd0, e0, l0, rd1, e1, l1);
    check("wr10_latency", 32'(l0), 32'd3);
    check("wr10_error", 32'(e0), 32'h0);
    check("wr10_rdata", rd0, 32'hfa11_1eaf);
    check("wr10_i1_latency", 32'(l1), 32'd1);
    check("wr10_i1_error", 32'(e1), 32'h1);
    txn(1'b0, 4'h0, 32'h10, 32'h0, rd0, e0, l0, rd1, e1, l1);
    check("rd10_latency", 32'(l0), 32'd3);
    check("rd10_rdata", rd0, 32'h1234_5678);
    check("rd10_error", 32'(e0), 32'h0);

    // Byte-lane merge.
    txn(1'b1, 4'hF, 32'h20, 32'hAABB_CCDD, rd0, e0, l0, rd1, e1, l1);
    txn(1'b1, 4'b0101, 32'h20, 32'h1122_3344, rd0, e0, l0, rd1, e1, l1);
    txn(1'b0, 4'h0, 32'h20, 32'h0, rd0, e0, l0, rd1, e1, l1);
    check("be_merge", rd0, 32'hAA22_CC44);

    // Out-of-range read and write.
    txn(1'b1, 4'hF, 32'h0, 32'h0BAD_F00D, rd0, e0, l0, rd1, e1, l1);
    txn(1'b0, 4'h0, 32'h4000, 32'h0, rd0, e0, l0, rd1, e1, l1);
    check("oor_rd_ready", 32'(l0), 32'd3);
    check("oor_rd_error", 32'(e0), 32'h1);
    check("oor_rd_rdata", rd0, 32'hdead_beef);
    txn(1'b1, 4'hF, 32'h4000, 32'hFFFF_FFFF, rd0, e0, l0, rd1, e1, l1);
    check("oor_wr_error", 32'(e0), 32'h1);
    txn(1'b0, 4'h0, 32'h0, 32'h0, rd0, e0, l0, rd1, e1, l1);
    check("oor_wr_no_alias", rd0, 32'h0BAD_F00D);

    // Misaligned write.
    txn(1'b1, 4'hF, 32'h4, 32'h5555_0004, rd0, e0, l0, rd1, e1, l1);
    txn(1'b1, 4'hF, 32'h6, 32'hFFFF_FFFF, rd0, e0, l0, rd1, e1, l1);
    check("misal_error", 32'(e0), 32'h1);
    check("misal_rdata", rd0, 32'hdead_beef);
    txn(1'b0, 4'h0, 32'h4, 32'h0, rd0, e0, l0, rd1, e1, l1);
    check("misal_no_write", rd0, 32'h5555_0004);

    // Request held high for 12 edges; write data changes every cycle.
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h1000; wd = 32'hC0DE_0000;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      r0[i] = bus0.ready_o;
      r1[i] = bus1.ready_o;
      wd = 32'hC0DE_0000 + 32'(i + 1);
    end
    req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("held_i1_ready_%0d", i), 32'(r1[i]), 32'(i % 2 == 0));
      check($sformatf("held_i0_ready_%0d", i), 32'(r0[i]), 32'(i == 2 || i == 6 || i == 10));
    end
    txn(1'b0, 4'h0, 32'h1000, 32'h0, rd0, e0, l0, rd1, e1, l1);
    check("held_i0_data", rd0, 32'hC0DE_0008);
    check("held_i1_data", rd1, 32'hC0DE_000A);

    // Reset while a LATENCY=3 write is waiting.
    txn(1'b1, 4'hF, 32'h30, 32'h0, rd0, e0, l0, rd1, e1, l1);
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h30; wd = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_i1_ready", 32'(bus1.ready_o), 32'h0);
    check("arst_i1_error", 32'(bus1.error_o), 32'h0);
    check("arst_i1_rdata", bus1.read_data_o, 32'hfa11_1eaf);
    check("arst_i0_rdata", bus0.read_data_o, 32'hfa11_1eaf);
    pulses = 0;
    repeat (3) begin @(negedge clk); if (bus0.ready_o) pulses++; end
    #1 rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (bus0.ready_o) pulses++; end
    check("arst_no_ready", 32'(pulses), 32'h0);
    txn(1'b0, 4'h0, 32'h30, 32'h0, rd0, e0, l0, rd1, e1, l1);
    check("arst_no_write", rd0, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      req = ($urandom_range(0, 99) < 60);
      we  = 1'($urandom);
      be  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case ($urandom_range(0, 5))
        0, 1:    addr = {25'h0, 5'($urandom), 2'b00};
        2, 3:    addr = 32'h1000 + {25'h0, 5'($urandom), 2'b00};
        4:       addr = $urandom;
        default: addr = {25'h0, 5'($urandom), 2'($urandom_range(1, 3))};
      endcase
      wd = $urandom;
    end
    req = 1'b0;
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
